// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU frame receiver: FSM state encoding
// and the CRC-16/MODBUS and addressing constants.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,  // waiting for a 3.5-character silence before trusting the line
    ST_READY   = 3'd1,  // idle between frames, next byte starts a frame
    ST_RECV    = 3'd2,  // collecting bytes of a frame
    ST_GAP     = 3'd3,  // 1.5-character silence seen, frame ends unless a byte intrudes
    ST_DISCARD = 3'd4,  // broken frame, swallow bytes until the line goes quiet
    ST_HOLD    = 3'd5   // complete frame held in the buffer for the consumer
  } state_t;

  localparam logic [15:0] CRC_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC_POLY       = 16'hA001;
  localparam logic [7:0]  BROADCAST_ADDR = 8'h00;

endpackage

// File: rtl/modbus_crc16.sv
// Combinational byte-wise CRC-16/MODBUS update (reflected polynomial).
module modbus_crc16
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_work;

  // Fold the byte into the register LSB first, eight shift/xor steps in one cycle.
  always_comb begin
    // NOTE: blocking assignments here on purpose: each loop step must see the
    // previous step's value within the same evaluation.
    crc_work = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY) : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: delimits frames by line silence, writes bytes
// into an external frame buffer with zero latency, checks length/CRC/address
// and holds a good frame until the consumer acknowledges it.
module modbus_rtu_frame_rx
  import modbus_pkg::*;
#(
  parameter int T15_CYCLES = 1563,
  parameter int T35_CYCLES = 3646,
  parameter int MAX_LEN    = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_err,
  input  logic [7:0] i_slave_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_valid,
  output logic [8:0] o_frame_len,
  output logic       o_crc_ok,
  output logic       o_addr_match,
  input  logic       i_frame_ack,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int               SIL_W   = $clog2(T35_CYCLES + 1);
  localparam logic [SIL_W-1:0] SIL_T15 = SIL_W'(T15_CYCLES);
  localparam logic [SIL_W-1:0] SIL_T35 = SIL_W'(T35_CYCLES);
  localparam logic [8:0]       LEN_MIN = 9'd4;
  localparam logic [8:0]       LEN_MAX = 9'(MAX_LEN);

  state_t           state_q, state_d;
  logic [SIL_W-1:0] silence_q;
  logic [8:0]       len_q;
  logic [15:0]      crc_q, crc_seed, crc_next;
  logic             err_q;
  logic             addr_match_q;
  logic             frame_valid_q;
  logic [8:0]       frame_len_q;
  logic             crc_ok_q;
  logic             frame_err_q;
  logic             overrun_q;

  // FSM decisions, consumed by the datapath register block
  logic start, append, overflow, eval_good, eval_bad, release_buf, set_overrun;
  logic t15_hit, t35_hit, frame_good;

  assign t15_hit    = (silence_q >= SIL_T15);
  assign t35_hit    = (silence_q == SIL_T35);
  assign frame_good = (len_q >= LEN_MIN) && (len_q <= LEN_MAX) && !err_q;

  // The first byte of a frame starts from the init value, later bytes chain.
  assign crc_seed = (state_q == ST_READY) ? CRC_INIT : crc_q;

  modbus_crc16 u_crc (
    .crc_in  (crc_seed),
    .byte_in (i_rx_data),
    .crc_out (crc_next)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_rst_n) state_q <= ST_SYNC;
    else          state_q <= state_d;
  end

  // Next-state and control decode; a byte in the same cycle as a silence
  // threshold always takes priority over the threshold action.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d     = state_q;
    start       = 1'b0;
    append      = 1'b0;
    overflow    = 1'b0;
    eval_good   = 1'b0;
    eval_bad    = 1'b0;
    release_buf = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (!i_rx_valid && t35_hit) state_d = ST_READY;
      end
      ST_READY: begin
        if (i_rx_valid) begin
          start   = 1'b1;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (i_rx_valid) begin
          if (len_q == LEN_MAX) overflow = 1'b1;
          else                  append   = 1'b1;
        end else if (t15_hit) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (i_rx_valid) begin
          state_d = ST_DISCARD;
        end else if (t35_hit) begin
          if (frame_good) begin
            eval_good = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            eval_bad  = 1'b1;
            state_d   = ST_READY;
          end
        end
      end
      ST_DISCARD: begin
        if (!i_rx_valid && t35_hit) begin
          eval_bad = 1'b1;
          state_d  = ST_READY;
        end
      end
      ST_HOLD: begin
        set_overrun = i_rx_valid;
        if (i_frame_ack) begin
          release_buf = 1'b1;
          state_d     = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Silence counter; also restarted on release so SYNC needs a fresh 3.5-char gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       silence_q <= '0;
    else if (i_rx_valid || release_buf) silence_q <= '0;
    else if (silence_q != SIL_T35)      silence_q <= silence_q + SIL_W'(1);
  end

  // Frame accumulation (length, CRC, error, address) and held result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q         <= '0;
      crc_q         <= CRC_INIT;
      err_q         <= 1'b0;
      addr_match_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      crc_ok_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_err_q <= eval_bad;
      if (start) begin
        len_q        <= 9'd1;
        crc_q        <= crc_next;
        err_q        <= i_rx_err;
        addr_match_q <= (i_rx_data == i_slave_addr) || (i_rx_data == BROADCAST_ADDR);
      end
      if (append) begin
        len_q <= len_q + 9'd1;
        crc_q <= crc_next;
        if (i_rx_err) err_q <= 1'b1;
      end
      // An overlong frame keeps its length saturated and is marked bad.
      if (overflow) err_q <= 1'b1;
      if (eval_good) begin
        frame_valid_q <= 1'b1;
        frame_len_q   <= len_q;
        crc_ok_q      <= (crc_q == 16'h0000);
      end
      if (release_buf) begin
        frame_valid_q <= 1'b0;
        frame_len_q   <= '0;
        crc_ok_q      <= 1'b0;
      end
      if (set_overrun) overrun_q <= 1'b1;
    end
  end

  // Buffer writes leave in the same cycle as the strobe; idle bus reads zero.
  assign o_wr_en       = start | append;
  assign o_wr_addr     = append ? len_q[7:0] : 8'h00;
  assign o_wr_data     = o_wr_en ? i_rx_data : 8'h00;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_len   = frame_len_q;
  assign o_crc_ok      = crc_ok_q;
  assign o_addr_match  = addr_match_q;
  assign o_frame_err   = frame_err_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Self-checking bench for modbus_rtu_frame_rx: a table of fixed frames, a few
// hand-written timing corner sequences and randomized frames checked against
// a frame-level reference model.
module tb_modbus_rtu_frame_rx;

  localparam int T15       = 15;
  localparam int T35       = 35;
  localparam int MAXL      = 256;
  localparam int CHAR_IDLE = 8;   // idle clocks between strobes: one character = 10 clocks

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_err = 1'b0;
  logic [7:0] i_slave_addr = 8'h01;
  logic       i_frame_ack = 1'b0;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_valid;
  logic [8:0] o_frame_len;
  logic       o_crc_ok;
  logic       o_addr_match;
  logic       o_frame_err;
  logic       o_overrun;

  modbus_rtu_frame_rx #(
    .T15_CYCLES (T15),
    .T35_CYCLES (T35),
    .MAX_LEN    (MAXL)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .i_rx_err      (i_rx_err),
    .i_slave_addr  (i_slave_addr),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_frame_valid (o_frame_valid),
    .o_frame_len   (o_frame_len),
    .o_crc_ok      (o_crc_ok),
    .o_addr_match  (o_addr_match),
    .i_frame_ack   (i_frame_ack),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Buffer image and event counters seen by the monitor
  logic [7:0] wmem [0:255];
  int         wcount = 0;
  bit         seq_bad = 0;
  int         err_cnt = 0;

  // Current frame under test: bytes, idle clocks before each byte, error flags
  logic [7:0] fb [$];
  int         sp [$];
  bit         ef [$];

  typedef struct {
    string             name;
    logic [0:15][7:0]  data;
    int                n;
    int                err_at;
    bit                ev;
    int                elen;
    bit                ecrc;
    bit                eam;
  } vec_t;

  vec_t vt [6];

  // Monitor: records buffer writes (must be strictly sequential) and error pulses.
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      if (int'(o_wr_addr) != wcount) seq_bad = 1;
      wmem[o_wr_addr] = o_wr_data;
      wcount++;
    end
    if (o_frame_err) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    i_rx_err   = e;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_rx_err   = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic send_q();
    for (int i = 0; i < fb.size(); i++) begin
      if (i > 0) idle(sp[i]);
      send_byte(fb[i], ef[i]);
    end
  endtask

  task automatic load_vec(input logic [0:15][7:0] d, input int n, input int err_at);
    fb.delete(); sp.delete(); ef.delete();
    for (int j = 0; j < n; j++) begin
      fb.push_back(d[j]);
      sp.push_back(CHAR_IDLE);
      ef.push_back(j == err_at);
    end
  endtask

  task automatic pulse_ack();
    @(posedge i_clk); #1;
    i_frame_ack = 1'b1;
    @(posedge i_clk); #1;
    i_frame_ack = 1'b0;
  endtask

  // CRC-16/MODBUS of the first n bytes of the current frame.
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Frame-level reference: what a receiver must report for the current frame.
  function automatic void model(input int gap_at, output bit v, output int len,
                                output bit cok, output bit am);
    bit anyerr = 0;
    len = fb.size();
    foreach (ef[i]) if (ef[i]) anyerr = 1;
    v   = (gap_at < 0) && (len >= 4) && (len <= MAXL) && !anyerr;
    cok = (crc_of(len) == 16'h0000);
    am  = (fb[0] == 8'h01) || (fb[0] == 8'h00);
  endfunction

  // Wait (bounded) for a held frame or an error pulse.
  task automatic wait_outcome(output bit gv, output bit ge);
    int base;
    base = err_cnt;
    gv = 0;
    ge = 0;
    for (int i = 0; i < 4 * T35; i++) begin
      @(negedge i_clk); #1;
      if (o_frame_valid) begin gv = 1; break; end
      if (err_cnt != base) begin ge = 1; break; end
    end
  endtask

  task automatic ack_release(input string name, input int settle);
    pulse_ack();
    check({name, ".released"}, 32'(o_frame_valid), 32'd0);
    idle(settle);
  endtask

  task automatic expect_outcome(input string name, input bit ev, input int elen,
                                input bit ecrc, input bit eam);
    int base, bad, nw;
    bit gv, ge;
    base = err_cnt;
    wait_outcome(gv, ge);
    check({name, ".valid"}, 32'(gv), 32'(ev));
    if (gv) begin
      check({name, ".len"}, 32'(o_frame_len), 32'(elen));
      check({name, ".crc_ok"}, 32'(o_crc_ok), 32'(ecrc));
      check({name, ".addr_match"}, 32'(o_addr_match), 32'(eam));
      nw  = (elen < 256) ? elen : 256;
      bad = 0;
      for (int i = 0; i < nw; i++) if (wmem[i] !== fb[i]) bad++;
      check({name, ".writes"}, 32'(wcount), 32'(nw));
      check({name, ".wdata_bad"}, 32'(bad), 32'd0);
      check({name, ".no_err"}, 32'(err_cnt - base), 32'd0);
      ack_release(name, T35 + 10);
    end else begin
      idle(2 * T35);
      check({name, ".err_pulses"}, 32'(err_cnt - base), 32'd1);
      check({name, ".still_invalid"}, 32'(o_frame_valid), 32'd0);
    end
  endtask

  task automatic run_std(input string name);
    bit v, cok, am;
    int len;
    load_vec(vt[0].data, vt[0].n, -1);
    model(-1, v, len, cok, am);
    wcount = 0;
    send_q();
    expect_outcome(name, v, len, cok, am);
  endtask

  initial begin
    logic [15:0] c;
    bit          v, cok, am, gv, ge, saw_v;
    int          len, base;

    // Fixed vectors
    vt[0] = '{"std_read",      {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 64'h0}, 8, -1, 1, 8, 1, 1};
    vt[1] = '{"bad_crc_bcast", {8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 64'h0}, 8, -1, 1, 8, 0, 1};
    vt[2] = '{"foreign_addr",  {8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 64'h0}, 8, -1, 1, 8, 0, 0};
    vt[3] = '{"short_3",       {8'h01, 8'h03, 8'h00, 104'h0}, 3, -1, 0, 0, 0, 0};
    vt[4] = '{"min_len_4",     {8'h01, 8'h07, 112'h0}, 4, -1, 1, 4, 1, 1};
    vt[5] = '{"rx_err_byte5",  {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 64'h0}, 8, 5, 0, 0, 0, 0};
    fb.delete();
    fb.push_back(8'h01);
    fb.push_back(8'h07);
    c = crc_of(2);
    vt[4].data[2] = c[7:0];
    vt[4].data[3] = c[15:8];

    // Reset state
    idle(3); #1;
    check("reset_outputs", 32'({o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_len,
                                o_crc_ok, o_addr_match, o_frame_err, o_overrun}), 32'd0);
    i_rst_n = 1'b1;
    idle(T35 + 10);

    // Table-driven frames; a stray ack before each must be ignored
    for (int t = 0; t < 6; t++) begin
      pulse_ack();
      load_vec(vt[t].data, vt[t].n, vt[t].err_at);
      wcount = 0;
      send_q();
      expect_outcome(vt[t].name, vt[t].ev, vt[t].elen, vt[t].ecrc, vt[t].eam);
    end

    // Byte landing exactly when silence reaches T15 stays in the frame
    load_vec(vt[0].data, 8, -1);
    foreach (sp[i]) sp[i] = 14;
    wcount = 0;
    send_q();
    expect_outcome("tie_t15_byte_wins", 1, 8, 1, 1);

    // One clock later the frame has entered GAP and the byte breaks it
    load_vec(vt[0].data, 8, -1);
    sp[3] = 15;
    wcount = 0;
    send_q();
    check("t15_plus1.writes_before_gap", 32'(wcount), 32'd3);
    expect_outcome("t15_plus1", 0, 0, 0, 0);

    // Two-character gap after byte 3, then the clean frame is accepted
    load_vec(vt[0].data, 8, -1);
    sp[3] = 20;
    wcount = 0;
    send_q();
    check("gap2char.writes", 32'(wcount), 32'd3);
    expect_outcome("gap2char", 0, 0, 0, 0);
    run_std("after_gap");

    // 257 back-to-back bytes: no address wrap, one error pulse
    fb.delete(); sp.delete(); ef.delete();
    for (int j = 0; j < 257; j++) begin
      fb.push_back(8'($urandom_range(0, 255)));
      sp.push_back(0);
      ef.push_back(0);
    end
    model(-1, v, len, cok, am);
    wcount  = 0;
    seq_bad = 0;
    send_q();
    check("overlong.write_count", 32'(wcount), 32'd256);
    check("overlong.no_wrap", 32'(seq_bad), 32'd0);
    expect_outcome("overlong", v, len, cok, am);

    // Byte during HOLD: overrun set, held outputs untouched, no write
    load_vec(vt[0].data, 8, -1);
    wcount = 0;
    send_q();
    wait_outcome(gv, ge);
    check("hold.valid", 32'(gv), 32'd1);
    send_byte(8'h55, 1'b0);
    check("hold.overrun", 32'(o_overrun), 32'd1);
    check("hold.outputs_stable", 32'({o_frame_valid, o_frame_len, o_crc_ok, o_addr_match}),
          32'({1'b1, 9'd8, 1'b1, 1'b1}));
    check("hold.no_write", 32'(wcount), 32'd8);
    ack_release("hold", 0);

    // Right after release the receiver is in SYNC: an early frame is ignored
    idle(3);
    base   = err_cnt;
    wcount = 0;
    load_vec(vt[0].data, 8, -1);
    send_q();
    saw_v = 0;
    for (int i = 0; i < 2 * T35; i++) begin
      @(negedge i_clk); #1;
      if (o_frame_valid) saw_v = 1;
    end
    check("sync_after_ack.writes", 32'(wcount), 32'd0);
    check("sync_after_ack.no_valid", 32'(saw_v), 32'd0);
    check("sync_after_ack.no_err", 32'(err_cnt - base), 32'd0);
    run_std("after_sync");

    // Reset after byte 4: everything clears, no error pulse, next frame accepted
    load_vec(vt[0].data, 4, -1);
    base = err_cnt;
    send_q();
    idle(3); #1;
    i_rst_n = 1'b0;
    #1;
    check("midreset.outputs", 32'({o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_len,
                                   o_crc_ok, o_addr_match, o_frame_err, o_overrun}), 32'd0);
    idle(2); #1;
    i_rst_n = 1'b1;
    saw_v = 0;
    for (int i = 0; i < 2 * T35; i++) begin
      @(negedge i_clk); #1;
      if (o_frame_valid) saw_v = 1;
    end
    check("midreset.no_valid", 32'(saw_v), 32'd0);
    check("midreset.no_err", 32'(err_cnt - base), 32'd0);
    run_std("after_reset");

    // Randomized frames against the reference model
    for (int r = 0; r < 25; r++) begin
      int plen, gap_at;
      fb.delete(); sp.delete(); ef.delete();
      case ($urandom_range(0, 2))
        0:       fb.push_back(8'h01);
        1:       fb.push_back(8'h00);
        default: fb.push_back(8'($urandom_range(2, 255)));
      endcase
      plen = $urandom_range(0, 9);
      for (int j = 0; j < plen; j++) fb.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) begin
        c = crc_of(fb.size());
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
      end else begin
        fb.push_back(8'($urandom_range(0, 255)));
        fb.push_back(8'($urandom_range(0, 255)));
      end
      foreach (fb[i]) begin
        sp.push_back($urandom_range(0, 13));
        ef.push_back(0);
      end
      if ($urandom_range(0, 7) == 0) ef[$urandom_range(0, fb.size() - 1)] = 1;
      gap_at = -1;
      if ($urandom_range(0, 5) == 0) begin
        gap_at     = $urandom_range(1, fb.size() - 1);
        sp[gap_at] = $urandom_range(16, 30);
      end
      model(gap_at, v, len, cok, am);
      wcount = 0;
      send_q();
      expect_outcome($sformatf("rand%0d", r), v, len, cok, am);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
